po2_weight_encoder: RTL and testbench

//  Encodes a signed fixed-point weight into the sign + log2 form used by the power-of-two multiply:

---
 rtl/po2_weight_encoder_if.sv | 39 +++
 rtl/po2_weight_encoder.sv | 167 ++++++++++++++++
 tb/tb_po2_weight_encoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/po2_weight_encoder_if.sv
// Weight-load handshake bundle for the po2 weight encoder.
// master drives weights and out_ready; slave is the encoder.
interface po2_weight_encoder_if #(
  parameter int W = 16
);
  logic [W-1:0] weight;
  logic         in_v;
  logic         in_ready;
  logic         negative_weight;
  logic [W-1:0] log_2_weight;
  logic         zero_weight;
  logic         saturated;
  logic         out_v;
  logic         out_ready;

  modport master (
    output weight,
    output in_v,
    output out_ready,
    input  in_ready,
    input  negative_weight,
    input  log_2_weight,
    input  zero_weight,
    input  saturated,
    input  out_v
  );

  modport slave (
    input  weight,
    input  in_v,
    input  out_ready,
    output in_ready,
    output negative_weight,
    output log_2_weight,
    output zero_weight,
    output saturated,
    output out_v
  );
endinterface

// File: rtl/po2_weight_encoder.sv
// Encodes a signed Q(I).(W-I) weight to sign + right-shift amount
// (weight ~= (-1)^neg * 2^-k), rounding to nearest power of two.
// Ports: clk, rst (async, active low), bus (slave):
//   weight/in_v/in_ready   weight accept handshake
//   negative_weight, log_2_weight, zero_weight, saturated
//   out_v/out_ready        result handshake, held until taken
// Leading-one scan runs one bit per cycle from the MSB down.
module po2_weight_encoder #(
  parameter int W = 16,
  parameter int I = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  po2_weight_encoder_if.slave  bus
);

  localparam int FRAC = W - I;
  localparam int BW   = $clog2(W);
  localparam int PW   = BW + 2;

  localparam logic [BW-1:0] B_TOP = BW'(W - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [BW-1:0] B_ZRO = '0;

  localparam logic signed [PW-1:0] P_FRAC = PW'(FRAC);
  localparam logic signed [PW-1:0] P_ONE  = PW'(1);
  localparam logic signed [PW-1:0] P_ZRO  = '0;

  localparam logic [W-1:0] K_FRAC = W'(FRAC);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    SCAN,
    ROUND,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [W-1:0]  wreg;
  logic [W-1:0]  mag;
  logic          neg;
  logic [BW-1:0] b;

  logic          neg_q;
  logic [W-1:0]  k_q;
  logic          zero_q;
  logic          sat_q;

  logic                 lead;
  logic                 half;
  logic                 b_is0;
  logic [BW-1:0]        b_m1;
  logic signed [PW-1:0] p_raw;
  logic signed [PW-1:0] p_rnd;
  logic signed [PW-1:0] p_neg;
  logic                 p_pos;

  // Scan / rounding arithmetic on the current bit pointer.
  always_comb begin
    b_is0 = (b == B_ZRO);
    b_m1  = b - B_ONE;
    lead  = mag[b];
    // Bit below the leading one decides round-up; a tie
    // (exactly 1.5 * 2^p) lands here too and rounds up.
    half  = !b_is0 && mag[b_m1];
    p_raw = $signed({2'b00, b}) - P_FRAC;
    p_rnd = half ? (p_raw + P_ONE) : p_raw;
    p_neg = P_ZRO - p_rnd;
    p_pos = (p_rnd > P_ZRO);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.in_v) state_n = ABS;
      end
      ABS: begin
        state_n = SCAN;
      end
      SCAN: begin
        if (lead)       state_n = ROUND;
        else if (b_is0) state_n = DONE;
      end
      ROUND: begin
        state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg   <= '0;
      mag    <= '0;
      neg    <= 1'b0;
      b      <= '0;
      neg_q  <= 1'b0;
      k_q    <= '0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_v) wreg <= bus.weight;
        end
        ABS: begin
          // Most negative weight negates to itself, which is
          // the correct unsigned magnitude.
          mag <= wreg[W-1] ? (~wreg + 1'b1) : wreg;
          neg <= wreg[W-1];
          b   <= B_TOP;
        end
        SCAN: begin
          if (!lead) begin
            if (b_is0) begin
              zero_q <= 1'b1;
              neg_q  <= 1'b0;
              sat_q  <= 1'b0;
              k_q    <= K_FRAC;
            end else begin
              b <= b_m1;
            end
          end
        end
        ROUND: begin
          neg_q  <= neg;
          zero_q <= 1'b0;
          sat_q  <= p_pos;
          k_q    <= p_pos ? '0 : W'($unsigned(p_neg));
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.in_ready        = (state == IDLE);
    bus.out_v           = (state == DONE);
    bus.negative_weight = neg_q;
    bus.log_2_weight    = k_q;
    bus.zero_weight     = zero_q;
    bus.saturated       = sat_q;
  end

endmodule

// File: tb/tb_po2_weight_encoder.sv
// Randomized + directed bench for po2_weight_encoder,
// checked against an arithmetic nearest-power-of-two model.
module tb_po2_weight_encoder;

  localparam int W    = 16;
  localparam int I    = 4;
  localparam int FRAC = W - I;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  po2_weight_encoder_if #(.W(W)) bus ();

  po2_weight_encoder #(
    .W(W),
    .I(I)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nearest power of two by plain arithmetic:
  // value = mag / 2^FRAC, round up when mag >= 1.5 * 2^e.
  task automatic ref_model(
    input  logic [W-1:0] w,
    output bit           neg,
    output int           k,
    output bit           zero,
    output bit           sat,
    output int           lat
  );
    int mag;
    int e;
    int p;
    mag = w[W-1] ? (65536 - int'(w)) : int'(w);
    if (mag == 0) begin
      neg  = 1'b0;
      k    = FRAC;
      zero = 1'b1;
      sat  = 1'b0;
      lat  = W + 1;
    end else begin
      e = 0;
      while ((1 << (e + 1)) <= mag) e++;
      lat = W - e + 2;
      if (2 * mag >= 3 * (1 << e)) e++;
      p    = e - FRAC;
      sat  = (p > 0);
      k    = sat ? 0 : -p;
      neg  = w[W-1];
      zero = 1'b0;
    end
  endtask

  task automatic encode(input logic [W-1:0] w, input int hold);
    bit eneg;
    bit ezero;
    bit esat;
    int ek;
    int elat;
    int lat;
    ref_model(w, eneg, ek, ezero, esat, elat);
    @(negedge clk);
    for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.weight = w;
    bus.in_v   = 1'b1;
    @(posedge clk);
    #1 bus.in_v = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_v && lat < 40);
    chk("latency", 32'(lat), 32'(elat));
    chk("neg", 32'(bus.negative_weight), 32'(eneg));
    chk("k", 32'(bus.log_2_weight), 32'(ek));
    chk("zero", 32'(bus.zero_weight), 32'(ezero));
    chk("sat", 32'(bus.saturated), 32'(esat));
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.in_v   = 1'b1;
      bus.weight = ~w;
      @(posedge clk);
      #1;
      chk("hold_out_v", 32'(bus.out_v), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_k", 32'(bus.log_2_weight), 32'(ek));
      chk("hold_neg", 32'(bus.negative_weight), 32'(eneg));
      chk("hold_sat", 32'(bus.saturated), 32'(esat));
    end
    bus.in_v      = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_out_v", 32'(bus.out_v), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  logic [W-1:0] dir_w [12];

  initial begin
    logic [W-1:0] rw;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.weight    = '0;
    bus.in_v      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_v", 32'(bus.out_v), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_k", 32'(bus.log_2_weight), 32'd0);
    chk("rst_neg", 32'(bus.negative_weight), 32'd0);
    chk("rst_zero", 32'(bus.zero_weight), 32'd0);
    chk("rst_sat", 32'(bus.saturated), 32'd0);
    rst = 1'b1;

    dir_w = '{16'h0800, 16'hF400, 16'h0001, 16'h0000,
              16'h8000, 16'h3000, 16'h0400, 16'h0600,
              16'h1000, 16'h1800, 16'hFFFF, 16'h7FFF};
    foreach (dir_w[i]) encode(dir_w[i], (i == 5) ? 5 : 0);

    // Reset in the middle of a long scan.
    @(negedge clk);
    bus.weight = 16'h0001;
    bus.in_v   = 1'b1;
    @(posedge clk);
    #1 bus.in_v = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_out_v", 32'(bus.out_v), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    encode(16'h0800, 0);

    for (int n = 0; n < 200; n++) begin
      rw = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 1) == 1) rw = -rw;
      encode(rw, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
